// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the IF/ID hazard controller:
//   - MIPS opcode constants used by the source-register usage decode
//   - ID-slot state encoding
//   - sat_inc8 helper for the saturating stall counter
// No ports (package).
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // EMPTY: nothing held; FULL: held and issuable; STALL: held, blocked by a hazard.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } id_state_e;

    // Increment that sticks at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Fetch-side and issue-side handshake between the pipeline and hazard_ctrl.
//   i_if_valid / i_if_instr / o_if_ready : fetch offers an instruction to ID
//   o_id_valid / o_id_instr / i_ex_ready : ID issues the held instruction to EX
// Modports:
//   master : the pipeline around the controller (drives fetch and EX ready)
//   slave  : hazard_ctrl itself
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic        i_if_valid;
    logic [31:0] i_if_instr;
    logic        o_if_ready;
    logic        o_id_valid;
    logic [31:0] o_id_instr;
    logic        i_ex_ready;

    modport master (
        output i_if_valid, i_if_instr, i_ex_ready,
        input  o_if_ready, o_id_valid, o_id_instr
    );

    modport slave (
        input  i_if_valid, i_if_instr, i_ex_ready,
        output o_if_ready, o_id_valid, o_id_instr
    );

endinterface

// File: rtl/src_use.sv
// -----------------------------------------------------------------------------
// src_use
// Decodes which source registers an instruction actually reads.
// Ports:
//   instr   [31:16] in  : opcode/rs/rt fields of the held instruction
//   rs, rt  [4:0]   out : source register numbers
//   rs_used         out : rs is read and is not $0
//   rt_used         out : rt is read and is not $0
// rs is read by everything except J/JAL; rt is read by R-type, BEQ/BNE and SW.
// $0 is folded in here so a hardwired-zero read can never raise a hazard.
// -----------------------------------------------------------------------------
module src_use
    import mips_pkg::*;
(
    input  logic [31:16] instr,
    output logic [4:0]   rs,
    output logic [4:0]   rt,
    output logic         rs_used,
    output logic         rt_used
);

    logic [5:0] opcode;
    logic       rs_read;
    logic       rt_read;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rs_read = 1'b1;
        rt_read = 1'b0;
        case (opcode)
            OP_J, OP_JAL:                    rs_read = 1'b0;
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: rt_read = 1'b1;
            default: ;
        endcase
    end

    assign rs_used = rs_read && (rs != 5'd0);
    assign rt_used = rt_read && (rt != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// IF/ID register with load-use / RAW hazard stall, flush and a saturating
// stall-cycle counter.
// Ports:
//   i_clk, i_rst             : clock, asynchronous active-high reset
//   bus (hazard_ctrl_if.slave): fetch handshake in, issue handshake out
//   i_ex_memread, i_ex_wreg, i_ex_rd : EX-stage load flag, write enable, dest
//   i_mem_wreg, i_mem_rd     : MEM-stage write enable, dest
//   i_flush                  : taken branch/jump, kill the ID contents
//   o_stall                  : hazard stall active
//   o_stall_cnt [7:0]        : saturating count of stall cycles
// Build option:
//   HAZARD_FWD_EN defined   -> EX/MEM results are forwarded, stall on load-use only
//   HAZARD_FWD_EN undefined -> stall on any EX or MEM destination match
// -----------------------------------------------------------------------------
module hazard_ctrl
    import mips_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    hazard_ctrl_if.slave bus,
    input  logic         i_ex_memread,
    input  logic         i_ex_wreg,
    input  logic [4:0]   i_ex_rd,
    input  logic         i_mem_wreg,
    input  logic [4:0]   i_mem_rd,
    input  logic         i_flush,
    output logic         o_stall,
    output logic [7:0]   o_stall_cnt
);

    id_state_e   state;
    logic [31:0] id_instr;
    logic [7:0]  stall_cnt;

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_used;
    logic        rt_used;

    logic        ex_match;
    logic        mem_match;
    logic        load_use;
    logic        hazard_src;
    logic        hazard;
    logic        issue;
    logic        fetch;
    logic        stall_active;

    src_use u_src_use (
        .instr   (id_instr[31:16]),
        .rs      (rs),
        .rt      (rt),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    assign ex_match  = i_ex_wreg  && ((rs_used && (rs == i_ex_rd))  || (rt_used && (rt == i_ex_rd)));
    assign mem_match = i_mem_wreg && ((rs_used && (rs == i_mem_rd)) || (rt_used && (rt == i_mem_rd)));
    assign load_use  = i_ex_memread && ex_match;

`ifdef HAZARD_FWD_EN
    assign hazard_src = load_use;
`else
    assign hazard_src = load_use | ex_match | mem_match;
`endif

    // Only a held instruction can be hazarded.
    assign hazard = (state != EMPTY) && hazard_src;

    // Flush wins over everything: no issue, no stall indication, fetch dropped.
    assign issue        = (state == FULL) && bus.i_ex_ready && !hazard && !i_flush;
    assign stall_active = (state == STALL) && !i_flush;
    assign fetch        = bus.i_if_valid && bus.o_if_ready && !i_flush;

    // A NOP still uses its issue slot (so the slot drains) but is not a real issue.
    assign bus.o_id_valid = issue && (id_instr != 32'd0);
    assign bus.o_if_ready = (state == EMPTY) || issue;
    assign bus.o_id_instr = id_instr;
    assign o_stall        = stall_active;
    assign o_stall_cnt    = stall_cnt;

    // NOTE: state registers are written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= EMPTY;
            id_instr  <= 32'd0;
            stall_cnt <= 8'd0;
        end else begin
            if (stall_active) begin
                stall_cnt <= sat_inc8(stall_cnt);
            end

            if (i_flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (fetch) begin
                            state    <= FULL;
                            id_instr <= bus.i_if_instr;
                        end
                    end
                    FULL: begin
                        if (hazard) begin
                            state <= STALL;
                        end else if (issue) begin
                            if (fetch) begin
                                id_instr <= bus.i_if_instr;
                            end else begin
                                state <= EMPTY;
                            end
                        end
                    end
                    STALL: begin
                        if (!hazard) begin
                            state <= FULL;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations followed by randomized traffic, all of it also compared every
// cycle against a behavioural model of the ID slot.
// Honors HAZARD_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [31:0] I_LW   = 32'h8E09_0000; // lw  $t1, 0($s0)
    localparam logic [31:0] I_ADD  = 32'h012B_5020; // add $t2, $t1, $t3
    localparam logic [31:0] I_ADD0 = 32'h0000_5020; // add $t2, $0, $0
    localparam logic [31:0] I_NOP  = 32'h0000_0000;

    logic       i_clk;
    logic       i_rst;
    logic       i_ex_memread;
    logic       i_ex_wreg;
    logic [4:0] i_ex_rd;
    logic       i_mem_wreg;
    logic [4:0] i_mem_rd;
    logic       i_flush;
    logic       o_stall;
    logic [7:0] o_stall_cnt;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .bus          (bus.slave),
        .i_ex_memread (i_ex_memread),
        .i_ex_wreg    (i_ex_wreg),
        .i_ex_rd      (i_ex_rd),
        .i_mem_wreg   (i_mem_wreg),
        .i_mem_rd     (i_mem_rd),
        .i_flush      (i_flush),
        .o_stall      (o_stall),
        .o_stall_cnt  (o_stall_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_occ: an instruction sits in ID; m_stall: it is parked behind a hazard.
    bit          m_occ;
    bit          m_stall;
    logic [31:0] m_instr;
    int          m_cnt;

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] op;
        bit rs_rd;
        bit rt_rd;
        op    = w[31:26];
        rs_rd = !(op == 6'h02 || op == 6'h03);
        rt_rd = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);
        return (r != 5'd0) && ((rs_rd && w[25:21] == r) || (rt_rd && w[20:16] == r));
    endfunction

    function automatic bit rule_hazard(input logic [31:0] w);
        bit ex_hit;
        bit mem_hit;
        ex_hit  = i_ex_wreg && reads_reg(w, i_ex_rd);
        mem_hit = i_mem_wreg && reads_reg(w, i_mem_rd);
        if (FWD) return ex_hit && i_ex_memread;
        return ex_hit || mem_hit;
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_occ   <= 1'b0;
            m_stall <= 1'b0;
            m_instr <= 32'd0;
            m_cnt   <= 0;
        end else if (i_flush) begin
            m_occ   <= 1'b0;
            m_stall <= 1'b0;
        end else if (m_stall) begin
            m_cnt   <= (m_cnt < 255) ? m_cnt + 1 : 255;
            m_stall <= rule_hazard(m_instr);
        end else if (m_occ) begin
            if (rule_hazard(m_instr)) begin
                m_stall <= 1'b1;
            end else if (bus.i_ex_ready) begin
                m_occ <= bus.i_if_valid;
                if (bus.i_if_valid) m_instr <= bus.i_if_instr;
            end
        end else if (bus.i_if_valid) begin
            m_occ   <= 1'b1;
            m_instr <= bus.i_if_instr;
        end
    end

    always @(negedge i_clk) begin : cmp
        bit e_haz;
        bit e_issue;
        if (chk_en && !i_rst) begin
            e_haz   = m_occ && rule_hazard(m_instr);
            e_issue = m_occ && !m_stall && bus.i_ex_ready && !e_haz && !i_flush;
            check("cmp_if_ready",  32'(bus.o_if_ready), 32'(!m_occ || e_issue));
            check("cmp_id_valid",  32'(bus.o_id_valid), 32'(e_issue && m_instr != 32'd0));
            check("cmp_stall",     32'(o_stall),        32'(m_stall && !i_flush));
            check("cmp_stall_cnt", 32'(o_stall_cnt),    32'(m_cnt));
            check("cmp_id_instr",  bus.o_id_instr,      m_instr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.i_if_valid = 1'b0;
        bus.i_if_instr = 32'd0;
        bus.i_ex_ready = 1'b1;
        i_ex_memread   = 1'b0;
        i_ex_wreg      = 1'b0;
        i_ex_rd        = 5'd0;
        i_mem_wreg     = 1'b0;
        i_mem_rd       = 5'd0;
        i_flush        = 1'b0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] w);
        bus.i_if_valid = 1'b1;
        bus.i_if_instr = w;
    endtask

    task automatic load_in_ex(input logic [4:0] rd);
        i_ex_memread = 1'b1;
        i_ex_wreg    = 1'b1;
        i_ex_rd      = rd;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  op;
        if ($urandom_range(0, 9) == 0) return 32'd0;
        case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h02;
            2: op = 6'h03;
            3: op = 6'h04;
            4: op = 6'h05;
            5: op = 6'h23;
            6: op = 6'h2B;
            default: op = 6'h08;
        endcase
        w        = $urandom;
        w[31:26] = op;
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        i_rst = 1'b0;
        idle();
        #1 i_rst = 1'b1;

        // reset state
        @(negedge i_clk);
        check("rst_stall",    32'(o_stall),        32'd0);
        check("rst_cnt",      32'(o_stall_cnt),    32'd0);
        check("rst_id_valid", 32'(bus.o_id_valid), 32'd0);
        check("rst_id_instr", bus.o_id_instr,      32'd0);
        tick();
        i_rst  = 1'b0;
        chk_en = 1'b1;

        // load-use: LW then ADD $t2,$t1,$t3 with the LW in EX
        fetch(I_LW);
        @(negedge i_clk); check("if_ready_after_rst", 32'(bus.o_if_ready), 32'd1); tick();
        fetch(I_ADD);
        @(negedge i_clk);
        check("lw_issue",       32'(bus.o_id_valid), 32'd1);
        check("lw_issue_instr", bus.o_id_instr,      I_LW);
        tick();
        idle(); load_in_ex(5'd9);
        @(negedge i_clk);
        check("lu_no_issue",  32'(bus.o_id_valid), 32'd0);
        check("lu_pre_stall", 32'(o_stall),        32'd0);
        tick();
        idle();
        @(negedge i_clk);
        check("lu_stall",       32'(o_stall),        32'd1);
        check("lu_stall_valid", 32'(bus.o_id_valid), 32'd0);
        tick();
        @(negedge i_clk);
        check("lu_add_issue", 32'(bus.o_id_valid), 32'd1);
        check("lu_add_instr", bus.o_id_instr,      I_ADD);
        check("lu_unstall",   32'(o_stall),        32'd0);
        check("lu_cnt",       32'(o_stall_cnt),    32'd1);
        tick();

        // flush while stalled, with a competing fetch that must be dropped
        fetch(I_ADD);
        @(negedge i_clk); tick();
        idle(); load_in_ex(5'd9);
        @(negedge i_clk); tick();
        @(negedge i_clk); check("fl_in_stall", 32'(o_stall), 32'd1); tick();
        i_flush = 1'b1; fetch(I_LW);
        @(negedge i_clk);
        check("fl_stall_off", 32'(o_stall),        32'd0);
        check("fl_no_issue",  32'(bus.o_id_valid), 32'd0);
        tick();
        idle();
        @(negedge i_clk);
        check("fl_empty",     32'(bus.o_if_ready), 32'd1);
        check("fl_dropped",   32'(bus.o_id_valid), 32'd0);
        check("fl_cnt",       32'(o_stall_cnt),    32'd2);
        tick();

        // $0 never hazards, even against a load writing $0
        fetch(I_ADD0);
        @(negedge i_clk); tick();
        idle(); load_in_ex(5'd0); i_mem_wreg = 1'b1; i_mem_rd = 5'd0;
        @(negedge i_clk);
        check("zero_issue",    32'(bus.o_id_valid), 32'd1);
        check("zero_no_stall", 32'(o_stall),        32'd0);
        tick();
        idle();

        // NOP held but not issued; then EX back-pressure
        fetch(I_NOP);
        @(negedge i_clk); tick();
        fetch(I_ADD);
        @(negedge i_clk);
        check("nop_valid",    32'(bus.o_id_valid), 32'd0);
        check("nop_instr",    bus.o_id_instr,      I_NOP);
        check("nop_drains",   32'(bus.o_if_ready), 32'd1);
        tick();
        fetch(I_LW); bus.i_ex_ready = 1'b0;
        @(negedge i_clk);
        check("bp_ready", 32'(bus.o_if_ready), 32'd0);
        check("bp_valid", 32'(bus.o_id_valid), 32'd0);
        tick();
        @(negedge i_clk); check("bp_hold", bus.o_id_instr, I_ADD); tick();
        bus.i_ex_ready = 1'b1;
        @(negedge i_clk);
        check("bp_issue",       32'(bus.o_id_valid), 32'd1);
        check("bp_issue_instr", bus.o_id_instr,      I_ADD);
        tick();
        idle();
        @(negedge i_clk); check("bp_next_instr", bus.o_id_instr, I_LW); tick();

        // MEM-stage match: hazard only without forwarding
        fetch(I_ADD);
        @(negedge i_clk); tick();
        idle(); i_mem_wreg = 1'b1; i_mem_rd = 5'd9;
        @(negedge i_clk); check("mac_valid", 32'(bus.o_id_valid), 32'(FWD)); tick();
        idle();
        @(negedge i_clk); check("mac_stall", 32'(o_stall), 32'(!FWD)); tick();
        @(negedge i_clk); tick();

        // counter saturation over 300 hazard cycles
        fetch(I_ADD);
        @(negedge i_clk); tick();
        idle(); load_in_ex(5'd9);
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk); tick();
        end
        @(negedge i_clk);
        check("sat_cnt",   32'(o_stall_cnt), 32'd255);
        check("sat_stall", 32'(o_stall),     32'd1);

        // asynchronous reset in the middle of a stall
        #2 i_rst = 1'b1;
        #1;
        check("rst_mid_stall", 32'(o_stall),        32'd0);
        check("rst_mid_cnt",   32'(o_stall_cnt),    32'd0);
        check("rst_mid_instr", bus.o_id_instr,      32'd0);
        check("rst_mid_valid", 32'(bus.o_id_valid), 32'd0);
        idle();
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_mid_no_issue", 32'(bus.o_id_valid), 32'd0);
        check("rst_mid_ready",    32'(bus.o_if_ready), 32'd1);
        tick();

        // randomized traffic, checked by the compare process
        for (int k = 0; k < 3000; k++) begin
            i_rst          = ($urandom_range(0, 299) == 0);
            bus.i_if_valid = ($urandom_range(0, 3) != 0);
            bus.i_if_instr = rand_instr();
            bus.i_ex_ready = ($urandom_range(0, 3) != 0);
            i_ex_memread   = $urandom_range(0, 1) == 1;
            i_ex_wreg      = $urandom_range(0, 1) == 1;
            i_ex_rd        = 5'($urandom_range(0, 3));
            i_mem_wreg     = $urandom_range(0, 1) == 1;
            i_mem_rd       = 5'($urandom_range(0, 3));
            i_flush        = ($urandom_range(0, 15) == 0);
            @(negedge i_clk);
            tick();
        end
        i_rst = 1'b0;
        idle();
        @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
